// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM datapath: main FSM, ALU decode, NZCV flag register
// and condition gating of every architectural write.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb,
    StMemWrite, StExecuteR, StExecuteI, StAluWb, StBranch
  } state_e;

  state_e     state_q, state_d;
  logic       condex_q, condex;
  logic       nextpc, regw, memw, branch, aluop, irw;
  logic       dp_nowrite, arith, nowrite, pcs;
  logic [2:0] dp_ctrl;
  logic [1:0] flagw;
  logic       n, z, c, v;

  assign {n, z, c, v} = Flags;

  always_comb begin
    condex = 1'b0;
    case (Cond)
      4'b0000: condex = z;
      4'b0001: condex = !z;
      4'b0010: condex = c;
      4'b0011: condex = !c;
      4'b0100: condex = n;
      4'b0101: condex = !n;
      4'b0110: condex = v;
      4'b0111: condex = !v;
      4'b1000: condex = c && !z;
      4'b1001: condex = !c || z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = !z && (n == v);
      4'b1101: condex = z || (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // Data-processing decode of cmd; only applied to ALUControl when the state asks for ALUOp.
  always_comb begin
    dp_ctrl    = 3'b000;
    dp_nowrite = 1'b0;
    arith      = 1'b0;
    case (Funct[4:1])
      4'b0100: begin dp_ctrl = 3'b000; arith = 1'b1; end
      4'b0010: begin dp_ctrl = 3'b001; arith = 1'b1; end
      4'b0000: dp_ctrl = 3'b010;
      4'b1100: dp_ctrl = 3'b011;
      4'b0001: dp_ctrl = 3'b100;
      4'b1010: begin dp_ctrl = 3'b001; arith = 1'b1; dp_nowrite = 1'b1; end
      default: dp_nowrite = 1'b1;
    endcase
  end

  assign ALUControl = aluop ? dp_ctrl : 3'b000;
  assign flagw      = {Funct[0], Funct[0] & arith};
  assign nowrite    = (state_q == StAluWb) && dp_nowrite;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};

  always_comb begin
    state_d   = state_q;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    aluop     = 1'b0;
    irw       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    unique case (state_q)
      StFetch: begin
        irw = 1'b1; nextpc = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = Funct[5] ? StExecuteI : StExecuteR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1; state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01; regw = 1'b1; state_d = StFetch;
      end
      StMemWrite: begin
        AdrSrc = 1'b1; memw = 1'b1; state_d = StFetch;
      end
      StExecuteR: begin
        aluop = 1'b1; state_d = StAluWb;
      end
      StExecuteI: begin
        ALUSrcB = 2'b01; aluop = 1'b1; state_d = StAluWb;
      end
      StAluWb: begin
        regw = 1'b1; state_d = StFetch;
      end
      StBranch: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Write enables are held low for as long as reset is asserted.
  assign pcs      = ((Rd == 4'b1111) && regw) || branch;
  assign PCWrite  = reset && (nextpc || (pcs && condex_q));
  assign IRWrite  = reset && irw;
  assign RegWrite = reset && regw && condex_q && !nowrite;
  assign MemWrite = reset && memw && condex_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      Flags    <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) condex_q <= condex;
      if ((state_q == StExecuteR || state_q == StExecuteI) && condex_q) begin
        if (flagw[1]) Flags[3:2] <= ALUFlags[3:2];
        if (flagw[0]) Flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction sequences state by state
// and checks write enables, selects, ALU control and flags against hand-computed values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags;
  logic [3:0] wr;

  int n_chk  = 0;
  int n_pass = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags)
  );

  always #5 clk = ~clk;

  // {PCWrite, MemWrite, IRWrite, RegWrite}
  assign wr = {PCWrite, MemWrite, IRWrite, RegWrite};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r);
    Cond = c; Op = o; Funct = f; Rd = r;
    #1;
  endtask

  initial begin
    Cond = 4'b1110; Op = 2'b00; Funct = 6'b0; Rd = 4'b0; ALUFlags = 4'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_wr", wr, 4'b0000);
    chk("reset_flags", Flags, 4'b0000);
    chk("reset_srcb", {2'b00, ALUSrcB}, 4'b0010);
    reset = 1'b1;
    #1;
    chk("fetch_after_reset", wr, 4'b1010);

    // ADD R1,R2,R3
    set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
    nxt(); chk("add_decode_wr", wr, 4'b0000);
    nxt(); ALUFlags = 4'b1111; #1;
    chk("add_exec_aluctl", {1'b0, ALUControl}, 4'b0000);
    chk("add_exec_wr", wr, 4'b0000);
    nxt(); chk("add_aluwb_wr", wr, 4'b0001);
    chk("add_flags_kept", Flags, 4'b0000);
    nxt(); chk("add_back_fetch", wr, 4'b1010);

    // SUBS -> Z set, then BEQ taken
    set_instr(4'b1110, 2'b00, 6'b000101, 4'd1);
    nxt(); nxt(); ALUFlags = 4'b0100; #1;
    chk("subs_aluctl", {1'b0, ALUControl}, 4'b0001);
    nxt(); chk("subs_flags", Flags, 4'b0100);
    chk("subs_aluwb_wr", wr, 4'b0001);
    nxt(); set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
    chk("beq_regsrc", {2'b00, RegSrc}, 4'b0001);
    nxt(); nxt(); chk("beq_taken_wr", wr, 4'b1000);
    nxt(); chk("beq_back_fetch", wr, 4'b1010);

    // SUBS -> Z clear, then BEQ not taken
    set_instr(4'b1110, 2'b00, 6'b000101, 4'd1);
    nxt(); nxt(); ALUFlags = 4'b0000; #1;
    nxt(); chk("subs2_flags", Flags, 4'b0000);
    nxt(); set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
    nxt(); nxt(); chk("beq_not_taken_wr", wr, 4'b0000);
    nxt();

    // CMP immediate
    set_instr(4'b1110, 2'b00, 6'b110101, 4'd0);
    nxt(); nxt(); ALUFlags = 4'b1010; #1;
    chk("cmp_aluctl", {1'b0, ALUControl}, 4'b0001);
    chk("cmp_srcb", {2'b00, ALUSrcB}, 4'b0001);
    nxt(); chk("cmp_flags", Flags, 4'b1010);
    chk("cmp_aluwb_wr", wr, 4'b0000);
    nxt();

    // LDR R2
    set_instr(4'b1110, 2'b01, 6'b011001, 4'd2);
    chk("ldr_regsrc_immsrc", {RegSrc, ImmSrc}, 4'b1001);
    nxt(); chk("ldr_decode_wr", wr, 4'b0000);
    nxt(); chk("ldr_memadr_src", {1'b0, ALUSrcA, ALUSrcB}, 4'b0001);
    nxt(); chk("ldr_memread_adr", {3'b000, AdrSrc}, 4'b0001);
    chk("ldr_memread_wr", wr, 4'b0000);
    nxt(); chk("ldr_memwb_res", {2'b00, ResultSrc}, 4'b0001);
    chk("ldr_memwb_wr", wr, 4'b0001);
    nxt(); chk("ldr_back_fetch", wr, 4'b1010);

    // LDR PC
    set_instr(4'b1110, 2'b01, 6'b011001, 4'd15);
    nxt(); nxt(); nxt(); nxt(); chk("ldr_pc_memwb_wr", wr, 4'b1001);
    nxt();

    // CMP setting Z, then STRNE (condition fails)
    set_instr(4'b1110, 2'b00, 6'b110101, 4'd0);
    nxt(); nxt(); ALUFlags = 4'b0100; #1;
    nxt(); chk("cmp2_flags", Flags, 4'b0100);
    nxt(); set_instr(4'b0001, 2'b01, 6'b011000, 4'd3);
    nxt(); nxt(); nxt(); chk("strne_memwrite_adr", {3'b000, AdrSrc}, 4'b0001);
    chk("strne_memwrite_wr", wr, 4'b0000);
    nxt(); chk("strne_back_fetch", wr, 4'b1010);

    // STR AL
    set_instr(4'b1110, 2'b01, 6'b011000, 4'd3);
    nxt(); nxt(); nxt(); chk("str_memwrite_wr", wr, 4'b0100);
    nxt(); chk("str_back_fetch", wr, 4'b1010);

    // Undefined Op=11
    set_instr(4'b1110, 2'b11, 6'b000000, 4'd0);
    nxt(); chk("undef_decode_wr", wr, 4'b0000);
    nxt(); chk("undef_back_fetch", wr, 4'b1010);

    // Reset asserted in the middle of an LDR
    set_instr(4'b1110, 2'b01, 6'b011001, 4'd2);
    nxt(); nxt(); nxt(); chk("rst_mid_memread_adr", {3'b000, AdrSrc}, 4'b0001);
    reset = 1'b0; #1;
    chk("rst_mid_wr", wr, 4'b0000);
    chk("rst_mid_flags", Flags, 4'b0000);
    chk("rst_mid_adr", {3'b000, AdrSrc}, 4'b0000);
    nxt(); chk("rst_mid_hold_wr", wr, 4'b0000);
    reset = 1'b1; #1;
    chk("rst_release_fetch", wr, 4'b1010);
    nxt(); chk("rst_release_decode", wr, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
